// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Define PS2_TX_RETRY_EN to retry a failed frame up to c_retries extra times.
module ps2_host_tx #(
  parameter int c_clk_hz      = 25000000,
  parameter int c_inhibit_us  = 100,
  parameter int c_timeout_ms  = 15,
  parameter int c_filter_bits = 3,
  parameter int c_retries     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int c_inh   = c_clk_hz / 1000000 * c_inhibit_us;
  localparam int c_to    = c_clk_hz / 1000 * c_timeout_ms;
  localparam int c_inh_w = $clog2(c_inh + 1);
  localparam int c_to_w  = $clog2(c_to + 1);
  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(c_inh - 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(c_to - 1);

  typedef logic [$clog2(c_retries + 2)-1:0] retry_cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_ACKEND
  } state_t;

  // Line conditioning: synchronise, then accept a level only after c_filter_bits equal samples.
  logic [1:0]               clk_sync, data_sync;
  logic [c_filter_bits-1:0] clk_hist, data_hist;
  logic                     clk_filt, data_filt, clk_filt_d;
  logic                     clk_fall;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_hist   <= '1;
      data_hist  <= '1;
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_hist   <= {clk_hist[c_filter_bits-2:0], clk_sync[1]};
      data_hist  <= {data_hist[c_filter_bits-2:0], data_sync[1]};
      if (&clk_hist)       clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      if (&data_hist)       data_filt <= 1'b1;
      else if (~|data_hist) data_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign clk_fall = clk_filt_d & ~clk_filt;

  state_t             state, state_n;
  logic [c_inh_w-1:0] inh_cnt, inh_cnt_n;
  logic [c_to_w-1:0]  to_cnt, to_cnt_n;
  logic [3:0]         bit_cnt, bit_cnt_n;
  logic [9:0]         sr, sr_n;
  logic               clk_oe_n, data_oe_n, done_n, ack_err_n, timeout_n;
  logic               fail_ack, fail_to, to_hit;
`ifdef PS2_TX_RETRY_EN
  retry_cnt_t         retry_cnt, retry_cnt_n;
`endif

  assign to_hit = (to_cnt == c_to_last);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_n   = state;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    timeout_n = 1'b0;
    fail_ack  = 1'b0;
    fail_to   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_cnt_n = retry_cnt;
`endif
    if (state inside {S_REQ, S_SHIFT, S_ACK, S_ACKEND}) to_cnt_n = to_cnt + 1'b1;

    // A line event in the same cycle as the timeout limit always takes priority.
    case (state)
      S_IDLE: if (tx_valid) begin
        sr_n      = {1'b1, ~^tx_data, tx_data};
        clk_oe_n  = 1'b1;
        inh_cnt_n = '0;
        state_n   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_n = '0;
`endif
      end
      S_INHIBIT: if (inh_cnt == c_inh_last) begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b1;
        to_cnt_n  = '0;
        state_n   = S_REQ;
      end else begin
        inh_cnt_n = inh_cnt + 1'b1;
      end
      S_REQ: if (clk_fall) begin
        bit_cnt_n = '0;
        state_n   = S_SHIFT;
      end else if (to_hit) fail_to = 1'b1;
      S_SHIFT: if (clk_fall) begin
        data_oe_n = ~sr[bit_cnt];
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == 4'd9) state_n = S_ACK;
      end else if (to_hit) fail_to = 1'b1;
      S_ACK: if (clk_fall) begin
        if (data_filt) fail_ack = 1'b1;
        else           state_n  = S_ACKEND;
      end else if (to_hit) fail_to = 1'b1;
      S_ACKEND: if (clk_filt && data_filt) begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        done_n    = 1'b1;
        state_n   = S_IDLE;
      end else if (to_hit) fail_to = 1'b1;
      default: state_n = S_IDLE;
    endcase

    if (fail_ack || fail_to) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt < retry_cnt_t'(c_retries)) begin
        retry_cnt_n = retry_cnt + 1'b1;
        clk_oe_n    = 1'b1;
        inh_cnt_n   = '0;
        state_n     = S_INHIBIT;
      end else begin
        ack_err_n = fail_ack;
        timeout_n = fail_to;
        state_n   = S_IDLE;
      end
`else
      ack_err_n = fail_ack;
      timeout_n = fail_to;
      state_n   = S_IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      bit_cnt     <= bit_cnt_n;
      sr          <= sr_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout     <= timeout_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= retry_cnt_n;
`endif
    end
  end

  assign tx_ready = (state == S_IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
// Scaled to a 1 MHz system clock: inhibit 100 cycles, timeout 5000 cycles, device half-period 40.
module tb_ps2_host_tx;

  localparam int INH   = 100;
  localparam int TO    = 5000;
  localparam int HALF  = 40;
  localparam int FRAME_BOUND = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk_in, ps2_data_in;
  logic       clk_oe, data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_err, timeout;

  logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
  bit   dev_enable = 1'b0, dev_ack = 1'b1, dev_glitch = 1'b0, dev_active = 1'b0;
  int   dev_rise = 0;
  logic [10:0] dev_bits, rx_frame;

  int compared = 0, mismatched = 0;
  int done_cnt = 0, ack_err_cnt = 0, timeout_cnt = 0, frame_cnt = 0, accept_cnt = 0;

  assign ps2_clk_in  = ~(clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_in = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .c_clk_hz(1000000), .c_inhibit_us(100), .c_timeout_ms(5),
    .c_filter_bits(3), .c_retries(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  // Pre-edge values are read here, so each one-cycle pulse is counted exactly once.
  always @(posedge clk) begin
    if (done === 1'b1)    done_cnt++;
    if (ack_err === 1'b1) ack_err_cnt++;
    if (timeout === 1'b1) timeout_cnt++;
    if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) accept_cnt++;
  end

  // Device: detects request-to-send, clocks 11 bits sampled on rising edges, then the ACK clock.
  initial begin : device
    forever begin
      @(negedge clk);
      if (dev_enable && ps2_data_in === 1'b0 && ps2_clk_in === 1'b1 && !dev_data_low) begin
        dev_active = 1'b1;
        dev_rise   = 0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          dev_bits[i] = ps2_data_in;
          dev_rise = i + 1;
          if (dev_glitch && i == 3) begin
            repeat (HALF / 2) @(negedge clk);
            glitch_low = 1'b1;
            @(negedge clk);
            glitch_low = 1'b0;
            repeat (HALF - HALF / 2 - 1) @(negedge clk);
          end else begin
            repeat (HALF) @(negedge clk);
          end
        end
        if (dev_ack) dev_data_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        dev_data_low = 1'b0;
        rx_frame = dev_bits;
        frame_cnt++;
        dev_active = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic settle(output bit ok);
    int g;
    g = 0;
    while ((dev_active || tx_ready !== 1'b1) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
    ok = (g < 20000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    compared++;
    if ({clk_oe, data_oe, tx_ready, busy, done, ack_err, timeout} !== 7'b0010000) begin
      mismatched++;
      $display("FAIL reset_state got %b want 0010000",
               {clk_oe, data_oe, tx_ready, busy, done, ack_err, timeout});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_send_ed();
    int d0, e0, t0, hi, g;
    bit ok;
    dev_enable = 1'b1;
    dev_ack = 1'b1;
    d0 = done_cnt; e0 = ack_err_cnt; t0 = timeout_cnt;
    send_byte(8'hED);
    hi = 0;
    while (clk_oe === 1'b1 && hi < INH + 50) begin
      hi++;
      @(negedge clk);
    end
    compared++;
    if (hi !== INH) begin
      mismatched++;
      $display("FAIL ed_inhibit_len got %0d want %0d", hi, INH);
    end
    compared++;
    if (data_oe !== 1'b1) begin
      mismatched++;
      $display("FAIL ed_rts_data_oe got %b want 1", data_oe);
    end
    g = 0;
    while (done !== 1'b1 && g < FRAME_BOUND) begin
      @(negedge clk);
      g++;
    end
    compared++;
    if (g >= FRAME_BOUND) begin
      mismatched++;
      $display("FAIL ed_done_wait got no done in %0d cycles want done", g);
    end
    @(negedge clk);
    compared++;
    if ({done, clk_oe, data_oe, tx_ready} !== 4'b0001) begin
      mismatched++;
      $display("FAIL ed_after_done got %b want 0001", {done, clk_oe, data_oe, tx_ready});
    end
    settle(ok);
    // ED has six ones, so odd parity is 1.
    compared++;
    if (rx_frame !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
      mismatched++;
      $display("FAIL ed_frame got %b want %b", rx_frame, {1'b1, 1'b1, 8'hED, 1'b0});
    end
    compared++;
    if ({done_cnt - d0, ack_err_cnt - e0, timeout_cnt - t0} !== {32'd1, 32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL ed_flag_counts got done=%0d ack_err=%0d timeout=%0d want 1 0 0",
               done_cnt - d0, ack_err_cnt - e0, timeout_cnt - t0);
    end
  endtask

  task automatic test_nack();
    int d0, e0, f0, g, want_frames;
    bit ok, early;
`ifdef PS2_TX_RETRY_EN
    want_frames = 3;
`else
    want_frames = 1;
`endif
    dev_enable = 1'b1;
    dev_ack = 1'b0;
    d0 = done_cnt; e0 = ack_err_cnt; f0 = frame_cnt;
    send_byte(8'h00);
    g = 0;
    early = 1'b0;
    while (g < 3 * FRAME_BOUND) begin
      @(negedge clk);
      g++;
      if (ack_err === 1'b1) break;
      if (tx_ready === 1'b1) early = 1'b1;
    end
    compared++;
    if (g >= 3 * FRAME_BOUND) begin
      mismatched++;
      $display("FAIL nack_wait got no ack_err in %0d cycles want ack_err", g);
    end
    compared++;
    if (early !== 1'b0) begin
      mismatched++;
      $display("FAIL nack_busy_held got tx_ready=1 before ack_err want 0");
    end
    settle(ok);
    dev_ack = 1'b1;
    compared++;
    if (rx_frame !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      mismatched++;
      $display("FAIL nack_frame got %b want %b", rx_frame, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    compared++;
    if ({frame_cnt - f0, ack_err_cnt - e0, done_cnt - d0} !== {want_frames, 32'd1, 32'd0}) begin
      mismatched++;
      $display("FAIL nack_counts got frames=%0d ack_err=%0d done=%0d want %0d 1 0",
               frame_cnt - f0, ack_err_cnt - e0, done_cnt - d0, want_frames);
    end
  endtask

  task automatic test_timeout();
    int cyc, g, d0;
    logic prev;
    bit ok;
    dev_enable = 1'b0;
    d0 = done_cnt;
    send_byte(8'h5A);
    cyc = 0; g = 0; prev = 1'b0;
    while (g < 3 * (TO + INH) + 500) begin
      @(negedge clk);
      g++;
      if (data_oe === 1'b1 && prev !== 1'b1) cyc = 0;
      else cyc++;
      prev = data_oe;
      if (timeout === 1'b1) break;
    end
    compared++;
    if (timeout !== 1'b1 || cyc !== TO) begin
      mismatched++;
      $display("FAIL timeout_latency got timeout=%b after %0d cycles want 1 after %0d", timeout, cyc, TO);
    end
    compared++;
    if ({clk_oe, data_oe, tx_ready} !== 3'b001) begin
      mismatched++;
      $display("FAIL timeout_release got %b want 001", {clk_oe, data_oe, tx_ready});
    end
    @(negedge clk);
    compared++;
    if ({timeout, tx_ready, busy} !== 3'b010) begin
      mismatched++;
      $display("FAIL timeout_next_cycle got %b want 010", {timeout, tx_ready, busy});
    end
    settle(ok);
    compared++;
    if (done_cnt !== d0) begin
      mismatched++;
      $display("FAIL timeout_no_done got %0d want %0d", done_cnt, d0);
    end
  endtask

  task automatic test_glitch();
    int d0, e0, g;
    bit ok;
    dev_enable = 1'b1;
    dev_ack = 1'b1;
    dev_glitch = 1'b1;
    d0 = done_cnt; e0 = ack_err_cnt;
    send_byte(8'hF4);
    g = 0;
    while (done_cnt == d0 && ack_err_cnt == e0 && g < FRAME_BOUND + INH) begin
      @(negedge clk);
      g++;
    end
    settle(ok);
    dev_glitch = 1'b0;
    // F4 has five ones, so odd parity is 0.
    compared++;
    if (rx_frame !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
      mismatched++;
      $display("FAIL glitch_frame got %b want %b", rx_frame, {1'b1, 1'b0, 8'hF4, 1'b0});
    end
    compared++;
    if ({done_cnt - d0, ack_err_cnt - e0} !== {32'd1, 32'd0}) begin
      mismatched++;
      $display("FAIL glitch_counts got done=%0d ack_err=%0d want 1 0", done_cnt - d0, ack_err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0, t0, g;
    bit ok;
    dev_enable = 1'b1;
    dev_ack = 1'b1;
    send_byte(8'h3C);
    g = 0;
    while (dev_rise != 5 && g < FRAME_BOUND) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    d0 = done_cnt; e0 = ack_err_cnt; t0 = timeout_cnt;
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({clk_oe, data_oe, busy, done, ack_err, timeout} !== 6'b000000) begin
      mismatched++;
      $display("FAIL midreset_release got %b want 000000",
               {clk_oe, data_oe, busy, done, ack_err, timeout});
    end
    reset = 1'b0;
    settle(ok);
    compared++;
    if (!ok || {done_cnt - d0, ack_err_cnt - e0, timeout_cnt - t0} !== {32'd0, 32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL midreset_no_flags got settle=%b done=%0d ack_err=%0d timeout=%0d want 1 0 0 0",
               ok, done_cnt - d0, ack_err_cnt - e0, timeout_cnt - t0);
    end
    compared++;
    if ({clk_oe, data_oe, tx_ready} !== 3'b001) begin
      mismatched++;
      $display("FAIL midreset_idle_traffic got %b want 001", {clk_oe, data_oe, tx_ready});
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, g;
    bit ok;
    dev_enable = 1'b1;
    dev_ack = 1'b1;
    a0 = accept_cnt; d0 = done_cnt;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'hFF;
    g = 0;
    while (done !== 1'b1 && g < FRAME_BOUND) begin
      @(negedge clk);
      g++;
    end
    compared++;
    if (accept_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL b2b_ignored_while_busy got %0d accepts want 1", accept_cnt - a0);
    end
    // A5 has four ones, so odd parity is 1.
    compared++;
    if (rx_frame !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
      mismatched++;
      $display("FAIL b2b_first_frame got %b want %b", rx_frame, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
    @(negedge clk);
    tx_valid = 1'b0;
    compared++;
    if (accept_cnt - a0 !== 2) begin
      mismatched++;
      $display("FAIL b2b_accept_after_done got %0d accepts want 2", accept_cnt - a0);
    end
    g = 0;
    while (done_cnt - d0 < 2 && g < FRAME_BOUND + INH) begin
      @(negedge clk);
      g++;
    end
    settle(ok);
    compared++;
    if (rx_frame !== {1'b1, 1'b1, 8'hFF, 1'b0} || done_cnt - d0 !== 2) begin
      mismatched++;
      $display("FAIL b2b_second_frame got %b done=%0d want %b done=2",
               rx_frame, done_cnt - d0, {1'b1, 1'b1, 8'hFF, 1'b0});
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_ed();
    test_nack();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
